// File: rtl/barrett_modmul_ctrl.sv
// rtl/barrett_modmul_ctrl.sv - Barrett modular multiply sequencer driving one shared 65x65 multiplier
// Define BARRETT_MU_CACHE_EN to keep k/mu for a repeated modulus and skip KCALC/DIV.
`timescale 1ns/1ps
module barrett_modmul_ctrl #(
  parameter int W = 64
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   in_a,
  input  logic [W-1:0]   in_b,
  input  logic [W-1:0]   in_q,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W-1:0]   out_t,
  output logic           out_err,
  output logic           mul_req,
  output logic [W:0]     mul_a,
  output logic [W:0]     mul_b,
  input  logic           mul_ack,
  input  logic [2*W+1:0] mul_p
);

  localparam int KW = $clog2(W) + 1;

  typedef enum logic [3:0] {
    IDLE, CHECK, KCALC, DIV, MUL_Z, MUL_M2, MUL_M3, SUB, DONE
  } state_t;

  state_t         state;
  logic [W-1:0]   a_r, b_r, q_r;
  logic [KW-1:0]  k;
  logic [KW:0]    div_cnt;
  logic           div_first;
  logic [W:0]     rem;
  logic [W:0]     mu;
  logic [2*W-1:0] z;
  logic [W:0]     m3;
  logic [W+1:0]   t;
  logic           sub_cnt;

  logic [W-1:0]   q_m1;
  logic [KW-1:0]  k_calc;
  logic           err_cond;
  logic           cache_hit;
  logic [W+1:0]   q_ext;
  logic [W+1:0]   rem_sh;
  logic [W:0]     rem_diff;
  logic           rem_geq;
  logic [W+1:0]   t_new;
  logic [W+1:0]   t_sub;

  assign in_ready = (state == IDLE) && !rst;
  assign q_m1     = q_r - W'(1);
  assign q_ext    = {2'b00, q_r};
  assign err_cond = (q_r < W'(2)) || (a_r >= q_r) || (b_r >= q_r);

  always_comb begin
    k_calc = '0;
    for (int i = 0; i < W; i++)
      if (q_m1[i]) k_calc = KW'(i + 1);
  end

  // Numerator 2^(2k) has a single one at its MSB, fed in on the first DIV cycle.
  assign rem_sh   = {rem, div_first};
  assign rem_geq  = rem_sh >= q_ext;
  assign rem_diff = rem_sh[W:0] - q_ext[W:0];

  assign t_new = (W+2)'(z - mul_p[2*W-1:0]);
  assign t_sub = t - q_ext;

`ifdef BARRETT_MU_CACHE_EN
  logic         cache_vld;
  logic [W-1:0] cache_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cache_vld <= 1'b0;
      cache_q   <= '0;
    end else if (state == DIV && div_cnt == '0) begin
      cache_vld <= 1'b1;
      cache_q   <= q_r;
    end
  end

  assign cache_hit = cache_vld && (cache_q == q_r);
`else
  assign cache_hit = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      a_r       <= '0;
      b_r       <= '0;
      q_r       <= '0;
      k         <= '0;
      div_cnt   <= '0;
      div_first <= 1'b0;
      rem       <= '0;
      mu        <= '0;
      z         <= '0;
      m3        <= '0;
      t         <= '0;
      sub_cnt   <= 1'b0;
      out_valid <= 1'b0;
      out_t     <= '0;
      out_err   <= 1'b0;
      mul_req   <= 1'b0;
      mul_a     <= '0;
      mul_b     <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          a_r   <= in_a;
          b_r   <= in_b;
          q_r   <= in_q;
          state <= CHECK;
        end
        CHECK: begin
          if (err_cond) begin
            out_err   <= 1'b1;
            out_t     <= '0;
            out_valid <= 1'b1;
            state     <= DONE;
          end else if (cache_hit) begin
            state <= MUL_Z;
          end else begin
            state <= KCALC;
          end
        end
        KCALC: begin
          k         <= k_calc;
          div_cnt   <= {k_calc, 1'b0};
          div_first <= 1'b1;
          rem       <= '0;
          mu        <= '0;
          state     <= DIV;
        end
        DIV: begin
          rem       <= rem_geq ? rem_diff : rem_sh[W:0];
          mu        <= {mu[W-1:0], rem_geq};
          div_first <= 1'b0;
          div_cnt   <= div_cnt - (KW+1)'(1);
          if (div_cnt == '0) state <= MUL_Z;
        end
        MUL_Z: begin
          if (!mul_req) begin
            mul_req <= 1'b1;
            mul_a   <= {1'b0, a_r};
            mul_b   <= {1'b0, b_r};
          end else if (mul_ack) begin
            mul_req <= 1'b0;
            z       <= mul_p[2*W-1:0];
            state   <= MUL_M2;
          end
        end
        MUL_M2: begin
          if (!mul_req) begin
            mul_req <= 1'b1;
            mul_a   <= (W+1)'(z >> k);
            mul_b   <= mu;
          end else if (mul_ack) begin
            mul_req <= 1'b0;
            m3      <= (W+1)'(mul_p >> k);
            state   <= MUL_M3;
          end
        end
        MUL_M3: begin
          if (!mul_req) begin
            mul_req <= 1'b1;
            mul_a   <= m3;
            mul_b   <= {1'b0, q_r};
          end else if (mul_ack) begin
            mul_req <= 1'b0;
            // Residue already reduced: skip SUB entirely.
            if (t_new < q_ext) begin
              out_t     <= t_new[W-1:0];
              out_valid <= 1'b1;
              state     <= DONE;
            end else begin
              t       <= t_new;
              sub_cnt <= 1'b0;
              state   <= SUB;
            end
          end
        end
        SUB: begin
          if (t_sub < q_ext || sub_cnt) begin
            out_t     <= t_sub[W-1:0];
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            t       <= t_sub;
            sub_cnt <= 1'b1;
          end
        end
        DONE: if (out_ready) begin
          out_valid <= 1'b0;
          out_err   <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Barrett error bound is 2q; needing a third subtraction means m3 was wrong.
  always_ff @(posedge clk) begin
    if (!rst && state == SUB && sub_cnt)
      assert (t_sub < q_ext);
  end

endmodule

// File: tb/tb_barrett_modmul_ctrl.sv
// tb/tb_barrett_modmul_ctrl.sv - directed bench for barrett_modmul_ctrl with a modelled shared multiplier
`timescale 1ns/1ps
module tb_barrett_modmul_ctrl;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [63:0]   in_a, in_b, in_q;
  logic          out_valid;
  logic          out_ready;
  logic [63:0]   out_t;
  logic          out_err;
  logic          mul_req;
  logic [64:0]   mul_a, mul_b;
  logic          mul_ack;
  logic [129:0]  mul_p;

  int total = 0;
  int bad = 0;
  int req_rises = 0;
  int stab_bad = 0;
  int hold_bad = 0;
  int mul_delay = 0;
  int wcnt = 0;
  logic req_prev = 1'b0;
  logic [64:0] sa, sb;

  always #5 clk = ~clk;

  barrett_modmul_ctrl #(.W(64)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_q(in_q),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_t(out_t), .out_err(out_err),
    .mul_req(mul_req), .mul_a(mul_a), .mul_b(mul_b),
    .mul_ack(mul_ack), .mul_p(mul_p)
  );

  // Shared multiplier: acks after mul_delay wait cycles, tracks request count and operand stability.
  initial begin : mul_model
    mul_ack = 1'b0;
    mul_p   = '0;
    forever begin
      @(negedge clk);
      mul_ack = 1'b0;
      if (mul_req && !req_prev) begin
        req_rises++;
        sa = mul_a;
        sb = mul_b;
        wcnt = 0;
      end
      if (mul_req && req_prev && (mul_a !== sa || mul_b !== sb)) stab_bad++;
      if (mul_req) begin
        if (wcnt >= mul_delay) begin
          mul_p   = {65'b0, mul_a} * {65'b0, mul_b};
          mul_ack = 1'b1;
        end
        wcnt++;
      end
      req_prev = mul_req;
    end
  end

  initial begin : watchdog
    #3000000;
    $display("FAIL watchdog: got timeout want test completion");
    $fatal(1, "watchdog expired");
  end

  task automatic run_op(input logic [63:0] a, input logic [63:0] b, input logic [63:0] q,
                        input int hold, output logic [63:0] t, output logic e,
                        output int lat, output int reqs);
    int r0;
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    r0 = req_rises;
    hold_bad = 0;
    in_a = a; in_b = b; in_q = q; in_valid = 1'b1;
    @(posedge clk);
    lat = 1;
    #1 in_valid = 1'b0;
    @(negedge clk);
    while (!out_valid && lat < 2000) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    if (!out_valid) begin
      lat = -1;
      t = '1;
      e = 1'bx;
      reqs = req_rises - r0;
      return;
    end
    t = out_t;
    e = out_err;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b1 || out_t !== t || out_err !== e) hold_bad++;
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    reqs = req_rises - r0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_a = '0; in_b = '0; in_q = '0;
    repeat (3) @(negedge clk);
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready: got %0b want 0", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %0b want 0", out_valid); end
    total++; if (out_t !== 64'd0) begin bad++; $display("FAIL reset_out_t: got %0h want 0", out_t); end
    total++; if (out_err !== 1'b0) begin bad++; $display("FAIL reset_out_err: got %0b want 0", out_err); end
    total++; if (mul_req !== 1'b0) begin bad++; $display("FAIL reset_mul_req: got %0b want 0", mul_req); end
    total++; if (mul_a !== 65'd0) begin bad++; $display("FAIL reset_mul_a: got %0h want 0", mul_a); end
    total++; if (mul_b !== 65'd0) begin bad++; $display("FAIL reset_mul_b: got %0h want 0", mul_b); end
    rst = 1'b0;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL release_in_ready: got %0b want 1", in_ready); end
  endtask

  task automatic test_basic();
    logic [63:0] vq[6], va[6], vb[6], vt[6];
    logic [63:0] t;
    logic e;
    int lat, reqs;
    vq = '{64'd7, 64'd2, 64'h1FFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0001, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1_0000_0000};
    va = '{64'd5, 64'd1, 64'h1FFF_FFFF_FFFF_FFFE, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF};
    vb = '{64'd6, 64'd1, 64'h1FFF_FFFF_FFFF_FFFE, 64'h7FFF_FFFF_FFFF_FFFB, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF};
    vt = '{64'd2, 64'd1, 64'd1, 64'd6, 64'd1, 64'd1};
    for (int i = 0; i < 6; i++) begin
      run_op(va[i], vb[i], vq[i], 0, t, e, lat, reqs);
      total++; if (t !== vt[i]) begin bad++; $display("FAIL basic_t[%0d]: got %0h want %0h", i, t, vt[i]); end
      total++; if (e !== 1'b0) begin bad++; $display("FAIL basic_err[%0d]: got %0b want 0", i, e); end
      total++; if (reqs != 3) begin bad++; $display("FAIL basic_reqs[%0d]: got %0d want 3", i, reqs); end
      if (i == 0) begin
        total++;
        if (lat < 16 || lat > 18) begin bad++; $display("FAIL basic_latency_q7: got %0d want 16..18", lat); end
      end
    end
  endtask

  task automatic test_errors();
    logic [63:0] vq[3], va[3], vb[3];
    logic [63:0] t;
    logic e;
    int lat, reqs;
    vq = '{64'd1, 64'd10, 64'd10};
    va = '{64'd0, 64'd10, 64'd3};
    vb = '{64'd0, 64'd3, 64'd11};
    for (int i = 0; i < 3; i++) begin
      run_op(va[i], vb[i], vq[i], 0, t, e, lat, reqs);
      total++; if (e !== 1'b1) begin bad++; $display("FAIL err_flag[%0d]: got %0b want 1", i, e); end
      total++; if (t !== 64'd0) begin bad++; $display("FAIL err_t[%0d]: got %0h want 0", i, t); end
      total++; if (lat != 2) begin bad++; $display("FAIL err_latency[%0d]: got %0d want 2", i, lat); end
      total++; if (reqs != 0) begin bad++; $display("FAIL err_reqs[%0d]: got %0d want 0", i, reqs); end
    end
  endtask

  task automatic test_wait_hold();
    logic [63:0] t;
    logic e;
    int lat, reqs, s0;
    s0 = stab_bad;
    mul_delay = 5;
    run_op(64'd5, 64'd6, 64'd7, 3, t, e, lat, reqs);
    mul_delay = 0;
    total++; if (t !== 64'd2) begin bad++; $display("FAIL wait_t: got %0h want 2", t); end
    total++; if (e !== 1'b0) begin bad++; $display("FAIL wait_err: got %0b want 0", e); end
    total++; if (reqs != 3) begin bad++; $display("FAIL wait_reqs: got %0d want 3", reqs); end
    total++; if (stab_bad != s0) begin bad++; $display("FAIL wait_operand_stable: got %0d changes want 0", stab_bad - s0); end
    total++; if (hold_bad != 0) begin bad++; $display("FAIL hold_outputs_stable: got %0d changes want 0", hold_bad); end
    total++; if (lat < 31 || lat > 33) begin bad++; $display("FAIL wait_latency: got %0d want 31..33", lat); end
  endtask

  task automatic test_back_to_back();
    logic [63:0] t1, t2, t3;
    logic e1, e2, e3;
    int lat1, lat2, lat3, r1, r2, r3;
    int want2;
    run_op(64'd1000002, 64'd2, 64'd1000003, 0, t1, e1, lat1, r1);
    run_op(64'd1000002, 64'd2, 64'd1000003, 0, t2, e2, lat2, r2);
    run_op(64'd123456, 64'd1000, 64'd1000003, 0, t3, e3, lat3, r3);
`ifdef BARRETT_MU_CACHE_EN
    want2 = lat1 - 42;
`else
    want2 = lat1;
`endif
    total++; if (t1 !== 64'd1000001 || e1 !== 1'b0) begin bad++; $display("FAIL b2b_first: got %0d err %0b want 1000001 err 0", t1, e1); end
    total++; if (t2 !== 64'd1000001 || e2 !== 1'b0) begin bad++; $display("FAIL b2b_second: got %0d err %0b want 1000001 err 0", t2, e2); end
    total++; if (t3 !== 64'd455631 || e3 !== 1'b0) begin bad++; $display("FAIL b2b_third: got %0d err %0b want 455631 err 0", t3, e3); end
    total++; if (lat1 < 50 || lat1 > 52) begin bad++; $display("FAIL b2b_latency_first: got %0d want 50..52", lat1); end
    total++; if (lat2 != want2) begin bad++; $display("FAIL b2b_latency_second: got %0d want %0d", lat2, want2); end
  endtask

  task automatic test_reset_mid_div();
    logic [63:0] t;
    logic e;
    int lat, reqs, r0, vcnt;
    @(negedge clk);
    in_a = 64'd1; in_b = 64'd1; in_q = 64'h1FFF_FFFF_FFFF_FFFF; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (10) @(negedge clk);
    r0 = req_rises;
    rst = 1'b1;
    #1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL middiv_in_ready_rst: got %0b want 0", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL middiv_out_valid_rst: got %0b want 0", out_valid); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL middiv_in_ready_release: got %0b want 1", in_ready); end
    vcnt = 0;
    repeat (200) begin
      @(negedge clk);
      if (out_valid) vcnt++;
    end
    total++; if (vcnt != 0) begin bad++; $display("FAIL middiv_spurious_valid: got %0d cycles want 0", vcnt); end
    total++; if (req_rises != r0) begin bad++; $display("FAIL middiv_spurious_req: got %0d want 0", req_rises - r0); end
    run_op(64'd5, 64'd6, 64'd7, 0, t, e, lat, reqs);
    total++; if (t !== 64'd2 || e !== 1'b0) begin bad++; $display("FAIL middiv_recover: got %0h err %0b want 2 err 0", t, e); end
    total++; if (lat < 16 || lat > 18) begin bad++; $display("FAIL middiv_recover_latency: got %0d want 16..18", lat); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_errors();
    test_wait_hold();
    test_back_to_back();
    test_reset_mid_div();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/barrett_modmul_ctrl.md
# barrett_modmul_ctrl

Sequencing controller for Barrett modular multiplication, t = (a·b) mod q. It accepts an operand triple over a valid/ready handshake and derives k = ⌈log2 q⌉ and mu = ⌊2^(2k)/q⌋ with an internal bit-serial divider. It then time-multiplexes one external shared 65×65 multiplier through three products (a·b, m1·mu, m3·q) and finishes with up to two conditional subtractions. It sits between the modular-arithmetic command stream and the shared multiplier resource.

## Interface
Parameters:
- W, 64, operand/modulus width (only 64 supported).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand triple valid.
- in_ready  out  1  controller can accept (high only in IDLE).
- in_a, in_b  in  64  multiplicands; each must be < in_q.
- in_q  in  64  modulus; must be ≥ 2.
- out_valid  out  1  result valid, held until out_ready.
- out_ready  in  1  consumer accepts result.
- out_t  out  64  residue.
- out_err  out  1  set when in_q < 2, in_a ≥ in_q or in_b ≥ in_q; out_t = 0 in that case.
- mul_req  out  1  multiplier request, held until mul_ack.
- mul_a, mul_b  out  65  multiplier operands, stable while mul_req is high.
- mul_ack  in  1  single-cycle pulse; mul_p is valid in the same cycle.
- mul_p  in  130  product.

## Operation
- States: IDLE → CHECK → KCALC → DIV → MUL_Z → MUL_M2 → MUL_M3 → SUB → DONE → IDLE.
- IDLE:
  - in_ready = 1.
  - on in_valid, latch a, b, q → CHECK.
- CHECK:
  - if the error condition is met → DONE with out_err = 1, out_t = 0.
  - else → KCALC.
- KCALC (1 cycle):
  - k = index of the MSB of (q−1), plus 1.
  - Powers of two yield k = log2 q; k ranges 1..64.
- DIV: restoring long division of 2^(2k) by q.
  - One quotient bit per cycle, MSB first, over 2k+1 numerator bits.
  - The remainder register is 65 bits.
  - Yields mu, which is 65 bits, ≤ 2^(k+1).
- MUL_Z: issue (a, b); on ack, z = mul_p[127:0].
- MUL_M2:
  - m1 = z >> k, which is < 2^k.
  - Issue (m1, mu); on ack, m3 = mul_p >> k, truncated to 65 bits.
- MUL_M3: issue (m3, q); on ack, t = z − mul_p[127:0], kept to 66 bits.
- SUB: while t ≥ q, t = t − q, one subtraction per cycle, maximum 2.
  - A third required subtraction is a design fault; this is an assertion target.
- DONE:
  - out_valid = 1, out_t = t[63:0].
  - On out_ready → IDLE.
- Multiplier handshake:
  - mul_req rises the cycle after entering a MUL state.
  - mul_req falls in the cycle after mul_ack.
  - mul_ack while mul_req is low is ignored.
- No new input is accepted before the result is consumed; there is one operation in flight.
- Reset (any state, including mid-DIV or with mul_req high):
  - all state cleared → IDLE.
  - mul_req, out_valid and out_err drop asynchronously.
  - An ack arriving after reset is ignored.

## Timing
- Reset values:
  - in_ready = 0 while rst is asserted, 1 in the first cycle after release.
  - out_valid, out_t, out_err, mul_req, mul_a and mul_b are all 0.
- Latency from the accept edge to out_valid, with a zero-wait multiplier (ack the cycle after req):
  - 1 (CHECK) + 1 (KCALC) + (2k+1) (DIV) + 3×2 (MUL) + s (SUB, 0..2) + 1.
  - For q = 7 (k = 3) that is 16+s cycles.
- An error path reaches out_valid 2 cycles after accept.
- Every multiplier wait cycle adds 1 cycle.
- out_valid with out_ready low holds all outputs stable indefinitely.

## Configuration
- BARRETT_MU_CACHE_EN:
  - Defined:
    - k, mu and cached q are retained after each successful operation.
    - If the next in_q equals cached q, KCALC and DIV are skipped: CHECK → MUL_Z.
    - Reset clears the cache-valid flag.
  - Undefined: KCALC and DIV run for every operation.
  - Results are identical either way.

## Test plan
- q=7, a=5, b=6, zero-wait mul:
  - out_t=2, out_err=0.
  - Internally mu=9, k=3.
  - out_valid 16–18 cycles after accept.
- q=2^61−1, a=b=q−1: out_t=1.
- q=2^63+1, a=2^63, b=2^63−5: out_t equals the golden model (Python pow); this exercises k=64, a 129-bit m2 and the 65-bit mu.
- Error cases, each with out_err=1, out_t=0, out_valid 2 cycles after accept and mul_req never asserted:
  - q=1.
  - q=10, a=10.
- mul_ack delayed 5 cycles per request, with out_ready held low 3 cycles: same result, mul_a/mul_b/out_t stable throughout, no duplicate request.
- Cache and reset:
  - Two back-to-back ops with q=1000003: with BARRETT_MU_CACHE_EN the second is 2k+2 = 42 cycles shorter.
  - rst pulsed mid-DIV: in_ready=1 after release, no spurious out_valid.
